axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares one AXI read channel (AR/R) between the instruction and data sram-like requesters.
//  Arbitrates read requests round-robin and issues single-beat ARs with a fixed ID per requester.
//  Tracks outstanding reads and routes R beats back by rid.
//  Holds off any data read that hits a pending write's word address (read-after-write ordering).
//  Sits between the CPU sram-like ports and the AXI crossbar; the write path is handled elsewhere.
// PARAMETERS
//  MAX_OUTST   2   max in-flight reads per requester (1..3); counter width 2
//  ID_INST     0   arid used for instruction reads
//  ID_DATA     1   arid used for data reads
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, synchronous, active-high
//  i_req        in   1   inst read request
//  i_addr       in   32  inst byte address
//  i_size       in   2   0=byte 1=half 2=word
//  i_addr_ok    out  1   inst request accepted this cycle
//  i_data_ok    out  1   inst read data valid
//  i_rdata      out  32  inst read data
//  d_req        in   1   data read request (reads only)
//  d_addr       in   32  data byte address
//  d_size       in   2   as i_size
//  d_addr_ok    out  1   data request accepted this cycle
//  d_data_ok    out  1   data read data valid
//  d_rdata      out  32  data read data
//  wr_pending   in   1   write path has an un-responded write
//  wr_addr      in   32  address of that write
//  arid         out  4   ID_INST/ID_DATA
//  araddr       out  32  registered request address
//  arsize       out  3   {1'b0,size}
//  arlen        out  8   const 0
//  arburst      out  2   const 2'b01
//  arlock/arcache/arprot  out  2/4/3  const 0
//  arvalid      out  1   AR valid
//  arready      in   1   AR ready
//  rid          in   4   R id
//  rdata        in   32  R data
//  rresp        in   2   R response
//  rlast        in   1   ignored (single beat)
//  rvalid       in   1   R valid
//  rready       out  1   R ready
//  rd_err       out  1   sticky: rresp!=0 or unknown rid seen
// BEHAVIOUR
//  Reset values: arvalid=0, araddr=0, arid=0, arsize=0; rready=0; all *_addr_ok/*_data_ok=0; rd_err=0.
//    Outstanding counters and the round-robin pointer (last=data) are also cleared.
//  AR FSM:
//    IDLE: pick a requester; pulse its *_addr_ok combinationally; latch addr/size/id; go to SEND.
//    SEND: arvalid=1 and fields stable until arready; on arvalid&arready return to IDLE.
//    Back-to-back ARs are issued with a 1-cycle IDLE gap.
//  Eligibility: req=1, state IDLE, requester count < MAX_OUTST.
//    Data is also blocked when wr_pending && wr_addr[31:2]==d_addr[31:2].
//  Arbitration: both eligible -> grant the one not granted last; pointer updates on grant only.
//  rready=1 every cycle after reset release.
//  On rvalid & rid==ID_INST: i_data_ok=1, i_rdata=rdata, inst count -1. Same for ID_DATA.
//    Any other rid is consumed without a data_ok and sets rd_err.
//  *_data_ok appear the same cycle as the R handshake (combinational); no buffering.
//  Counters: grant +1, return -1; both in one cycle -> unchanged.
//    Return at count 0 is ignored and sets rd_err.
//  rresp!=0 still returns data_ok (data passed through) and sets rd_err.
//  Requester dropping req while not accepted: no effect; addr_ok is never given without req.
//  Reset mid-transaction: FSM to IDLE and counters to 0 next cycle; arvalid deasserts.
//    In-flight R beats after reset are ignored (rready=0 during rst).
//  Latency: req to arvalid = 1 cycle; AR handshake to data_ok = slave latency, 0 added.
// STRUCTURE
//  Shared pkg axi_pkg: AXI_BURST_INCR, AXI size encodings, ID_INST/ID_DATA defaults,
//    sram-like size constants.
//  One sub-module: outst_counter (saturating up/down counter with full/underflow flags),
//    instantiated per requester.
//  AR FSM and RR pointer live in the top.
// TESTING
//  1 i_req, addr 0xBFC00000 size 2, arready=1 after 2 cycles
//    -> i_addr_ok cyc0; arvalid cyc1-3, arid 0, arsize 2; R(rid0, 0x3C080001) -> i_data_ok, i_rdata=0x3C080001.
//  2 i_req and d_req held high together, arready=1
//    -> grants alternate D,I,D,I (pointer starts at data-last, so first grant is inst... check: I,D,I,D);
//    arid pattern 0,1,0,1.
//  3 i_req held, no R returned -> exactly 2 i_addr_ok pulses (MAX_OUTST=2), then stall;
//    one R rid0 -> third i_addr_ok follows.
//  4 wr_pending=1, wr_addr 0x1000, d_req addr 0x1002 -> no d_addr_ok;
//    wr_pending drops -> d_addr_ok next IDLE cycle.
//  5 R rid 0x5 with rvalid, then R rid1 rresp=2 -> rd_err=1, no i_data_ok;
//    d_data_ok still pulses for the rid1 beat.
//  6 rst asserted while arvalid=1 -> next cycle arvalid=0, counts 0;
//    a following R beat produces no data_ok.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI constants and helpers for the read arbiter slice.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [2:0] AXI_SIZE_1B = 3'b000;
  localparam logic [2:0] AXI_SIZE_2B = 3'b001;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  localparam logic [3:0] ID_INST_DEF = 4'd0;
  localparam logic [3:0] ID_DATA_DEF = 4'd1;

  localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
  localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_e;

  // sram-like size codes map directly onto the low bits of the AXI size field
  function automatic logic [2:0] to_axi_size(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_outst_counter.sv
// Saturating up/down in-flight counter with full and underflow flags.
module outst_counter #(
  parameter int MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] count,
  output logic       full,
  output logic       underflow
);

  localparam logic [1:0] MAX_CNT = 2'(MAX);

  logic [1:0] count_reg;
  logic [1:0] count_next;
  logic       inc_eff;
  logic       dec_eff;

  assign full      = (count_reg >= MAX_CNT);
  assign underflow = dec && (count_reg == 2'd0);
  assign inc_eff   = inc && !full;
  assign dec_eff   = dec && (count_reg != 2'd0);
  assign count     = count_reg;

  always_comb begin
    count_next = count_reg;
    if (inc_eff && !dec_eff)
      count_next = count_reg + 2'd1;
    else if (!inc_eff && dec_eff)
      count_next = count_reg - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      count_reg <= 2'd0;
    else
      count_reg <= count_next;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between inst and data requesters,
// with per-requester outstanding tracking and read-after-write hold-off for data reads.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int         MAX_OUTST = 2,
  parameter logic [3:0] ID_INST   = ID_INST_DEF,
  parameter logic [3:0] ID_DATA   = ID_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  input  logic        wr_pending,
  input  logic [31:0] wr_addr,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rd_err
);

  ar_state_e   state_reg, state_next;
  logic [31:0] araddr_reg;
  logic [3:0]  arid_reg;
  logic [2:0]  arsize_reg;
  logic        last_data_reg;
  logic        rready_reg;
  logic        rd_err_reg;

  logic i_full, d_full, i_under, d_under;
  logic i_elig, d_elig, grant_i, grant_d, raw_block;
  logic r_fire, r_inst, r_data, r_unknown;
  logic [1:0] i_count, d_count;
  logic unused_bits;

  assign unused_bits = ^{rlast, wr_addr[1:0], i_count, d_count};

  assign raw_block = wr_pending && (wr_addr[31:2] == d_addr[31:2]);
  assign i_elig    = i_req && (state_reg == AR_IDLE) && !i_full;
  assign d_elig    = d_req && (state_reg == AR_IDLE) && !d_full && !raw_block;
  // On contention, favour whichever side did not win the previous grant
  assign grant_i   = i_elig && (!d_elig || last_data_reg);
  assign grant_d   = d_elig && (!i_elig || !last_data_reg);
  assign i_addr_ok = grant_i;
  assign d_addr_ok = grant_d;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      AR_IDLE: if (grant_i || grant_d) state_next = AR_SEND;
      AR_SEND: if (arready) state_next = AR_IDLE;
      default: state_next = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= AR_IDLE;
      araddr_reg    <= 32'd0;
      arid_reg      <= 4'd0;
      arsize_reg    <= 3'd0;
      last_data_reg <= 1'b1;
      rready_reg    <= 1'b0;
      rd_err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rready_reg <= 1'b1;
      if (grant_i) begin
        araddr_reg    <= i_addr;
        arid_reg      <= ID_INST;
        arsize_reg    <= to_axi_size(i_size);
        last_data_reg <= 1'b0;
      end else if (grant_d) begin
        araddr_reg    <= d_addr;
        arid_reg      <= ID_DATA;
        arsize_reg    <= to_axi_size(d_size);
        last_data_reg <= 1'b1;
      end
      if (r_fire && (rresp != 2'b00 || r_unknown || i_under || d_under))
        rd_err_reg <= 1'b1;
    end
  end

  assign arvalid = (state_reg == AR_SEND);
  assign araddr  = araddr_reg;
  assign arid    = arid_reg;
  assign arsize  = arsize_reg;
  assign arlen   = 8'd0;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = rready_reg;
  assign rd_err  = rd_err_reg;

  // Return path: beats are routed by ID; a beat with no matching outstanding read is dropped
  assign r_fire    = rvalid && rready_reg;
  assign r_inst    = r_fire && (rid == ID_INST);
  assign r_data    = r_fire && (rid == ID_DATA);
  assign r_unknown = r_fire && !(rid == ID_INST) && !(rid == ID_DATA);
  assign i_data_ok = r_inst && !i_under;
  assign d_data_ok = r_data && !d_under;
  assign i_rdata   = rdata;
  assign d_rdata   = rdata;

  outst_counter #(.MAX(MAX_OUTST)) u_cnt_inst (
    .clk       (clk),
    .rst       (rst),
    .inc       (grant_i),
    .dec       (r_inst),
    .count     (i_count),
    .full      (i_full),
    .underflow (i_under)
  );

  outst_counter #(.MAX(MAX_OUTST)) u_cnt_data (
    .clk       (clk),
    .rst       (rst),
    .inc       (grant_d),
    .dec       (r_data),
    .count     (d_count),
    .full      (d_full),
    .underflow (d_under)
  );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed scenarios plus a randomized phase checked by a queue-based scoreboard.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, wr_pending, arready, rvalid, rlast;
  logic [31:0] i_addr, d_addr, wr_addr, rdata;
  logic [1:0]  i_size, d_size, rresp;
  logic [3:0]  rid;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, arvalid, rready, rd_err;
  logic [31:0] i_rdata, d_rdata, araddr;
  logic [3:0]  arid, arcache;
  logic [2:0]  arsize, arprot;
  logic [7:0]  arlen;
  logic [1:0]  arburst, arlock;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_size(i_size), .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_size(d_size), .d_addr_ok(d_addr_ok),
    .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .wr_pending(wr_pending), .wr_addr(wr_addr),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arlen(arlen), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .rd_err(rd_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    i_req = 0; i_addr = 0; i_size = 2; d_req = 0; d_addr = 0; d_size = 2;
    wr_pending = 0; wr_addr = 0; arready = 1; rvalid = 0; rid = 0; rdata = 0;
    rresp = 0; rlast = 1;
  endtask

  // Present one R beat for a cycle and check where it is routed
  task automatic r_beat(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                        input logic exp_i, input logic exp_d, input string name);
    rvalid = 1; rid = id; rdata = data; rresp = resp;
    @(negedge clk);
    check({name, "_i_data_ok"}, i_data_ok, exp_i);
    check({name, "_d_data_ok"}, d_data_ok, exp_d);
    if (exp_i) check({name, "_i_rdata"}, i_rdata, data);
    if (exp_d) check({name, "_d_rdata"}, d_rdata, data);
    tick();
    rvalid = 0;
  endtask

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_t;

  ar_t         exp_ar[$];
  logic [31:0] rq_i[$], rq_d[$], exp_i[$], exp_d[$];
  int          out_i = 0, out_d = 0, n_gi = 0, n_gd = 0;
  bit          rand_on = 0;
  bit          i_fire_n, d_fire_n, r_fire_n;

  always @(negedge clk) begin
    i_fire_n = 0; d_fire_n = 0; r_fire_n = 0;
    if (rand_on) begin
      if (i_addr_ok) begin
        check("rnd_i_grant_has_req", {31'd0, i_req}, 1);
        check("rnd_i_within_max", {31'd0, out_i < 2}, 1);
        check("rnd_single_grant", {31'd0, d_addr_ok}, 0);
        exp_ar.push_back('{id: 4'd0, addr: i_addr, size: {1'b0, i_size}});
        out_i++; n_gi++; i_fire_n = 1;
      end
      if (d_addr_ok) begin
        check("rnd_d_grant_has_req", {31'd0, d_req}, 1);
        check("rnd_d_within_max", {31'd0, out_d < 2}, 1);
        check("rnd_d_raw_clear", {31'd0, wr_pending && (wr_addr[31:2] == d_addr[31:2])}, 0);
        exp_ar.push_back('{id: 4'd1, addr: d_addr, size: {1'b0, d_size}});
        out_d++; n_gd++; d_fire_n = 1;
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) check("rnd_ar_unexpected", 1, 0);
        else begin
          ar_t e;
          logic [31:0] dat;
          e = exp_ar.pop_front();
          check("rnd_arid", {28'd0, arid}, {28'd0, e.id});
          check("rnd_araddr", araddr, e.addr);
          check("rnd_arsize", {29'd0, arsize}, {29'd0, e.size});
          check("rnd_arlen_burst", {22'd0, arlen, arburst}, {22'd0, 8'd0, 2'b01});
          dat = $urandom;
          if (e.id == 4'd0) begin rq_i.push_back(dat); exp_i.push_back(dat); end
          else begin rq_d.push_back(dat); exp_d.push_back(dat); end
        end
      end
      if (rvalid && rready) begin
        r_fire_n = 1;
        if (rid == 4'd0 && rq_i.size() > 0) void'(rq_i.pop_front());
        if (rid == 4'd1 && rq_d.size() > 0) void'(rq_d.pop_front());
      end
      if (i_data_ok) begin
        if (exp_i.size() == 0) check("rnd_i_data_unexpected", 1, 0);
        else begin check("rnd_i_rdata", i_rdata, exp_i.pop_front()); out_i--; end
      end
      if (d_data_ok) begin
        if (exp_d.size() == 0) check("rnd_d_data_unexpected", 1, 0);
        else begin check("rnd_d_rdata", d_rdata, exp_d.pop_front()); out_d--; end
      end
    end
  end

  // Slave side of the random phase: toggling arready, R beats from either ID queue
  task automatic slave_step();
    arready = ($urandom % 3) != 0;
    if (r_fire_n) rvalid = 0;
    if (!rvalid && ($urandom % 2 == 0) && (rq_i.size() + rq_d.size() > 0)) begin
      rvalid = 1; rresp = 0;
      if (rq_d.size() == 0 || (rq_i.size() > 0 && $urandom % 2 == 0)) begin
        rid = 4'd0; rdata = rq_i[0];
      end else begin
        rid = 4'd1; rdata = rq_d[0];
      end
    end
  endtask

  logic [31:0] d_set [4] = '{32'h1000, 32'h1004, 32'h1002, 32'h2000};

  initial begin
    int cnt;
    int gseq [4];
    int aseq [4];
    int ng, na;
    defaults();
    rst = 1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_arvalid", {31'd0, arvalid}, 0);
    check("reset_araddr", araddr, 0);
    check("reset_arid_arsize", {25'd0, arid, arsize}, 0);
    check("reset_rready", {31'd0, rready}, 0);
    check("reset_ok_flags", {28'd0, i_data_ok, d_data_ok, i_addr_ok, d_addr_ok}, 0);
    check("reset_rd_err", {31'd0, rd_err}, 0);
    tick(); rst = 0;
    tick();
    @(negedge clk);
    check("rready_after_reset", {31'd0, rready}, 1);

    // Both requesting: round-robin starting with inst
    tick();
    i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h200; arready = 1;
    ng = 0; na = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (i_addr_ok && ng < 4) begin gseq[ng] = 0; ng++; end
      if (d_addr_ok && ng < 4) begin gseq[ng] = 1; ng++; end
      if (arvalid && arready && na < 4) begin aseq[na] = int'(arid); na++; end
      tick();
    end
    i_req = 0; d_req = 0;
    check("rr_grant_count", ng, 4);
    check("rr_ar_count", na, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_grant%0d", k), gseq[k], k % 2);
      check($sformatf("rr_arid%0d", k), aseq[k], k % 2);
    end
    $display("[TB] round-robin: %0d grants", ng);
    r_beat(0, 32'hA0, 0, 1, 0, "rr_ret0");
    r_beat(1, 32'hA1, 0, 0, 1, "rr_ret1");
    r_beat(0, 32'hA2, 0, 1, 0, "rr_ret2");
    r_beat(1, 32'hA3, 0, 0, 1, "rr_ret3");

    // Single inst read with arready delayed two cycles
    arready = 0; i_req = 1; i_addr = 32'hBFC00000; i_size = 2;
    @(negedge clk);
    check("t1_addr_ok", {31'd0, i_addr_ok}, 1);
    tick(); i_req = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) arready = 1;
      @(negedge clk);
      check($sformatf("t1_arvalid_c%0d", c), {31'd0, arvalid}, 1);
      check("t1_arfields", {arid, arsize, araddr[31:7]}, {4'd0, 3'd2, 25'h17F8000});
      tick();
    end
    arready = 0;
    @(negedge clk);
    check("t1_arvalid_c4", {31'd0, arvalid}, 0);
    tick();
    r_beat(0, 32'h3C080001, 0, 1, 0, "t1_ret");
    $display("[TB] single inst read done");

    // Outstanding limit
    arready = 1; i_req = 1; i_addr = 32'h40; cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); if (i_addr_ok) cnt++; tick();
    end
    check("t3_stall_grants", cnt, 2);
    r_beat(0, 32'hB0, 0, 1, 0, "t3_ret");
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); if (i_addr_ok) cnt++; tick();
    end
    check("t3_third_grant", cnt, 1);
    i_req = 0;
    r_beat(0, 32'hB1, 0, 1, 0, "t3_drain0");
    r_beat(0, 32'hB2, 0, 1, 0, "t3_drain1");
    $display("[TB] outstanding limit done");

    // Read-after-write hold-off on matching word address
    wr_pending = 1; wr_addr = 32'h1000; d_req = 1; d_addr = 32'h1002; d_size = 1; cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); if (d_addr_ok) cnt++; tick();
    end
    check("t4_blocked", cnt, 0);
    wr_pending = 0;
    @(negedge clk);
    check("t4_released", {31'd0, d_addr_ok}, 1);
    tick(); d_req = 0;
    repeat (3) tick();

    // Unknown rid, then error response on a real data read
    r_beat(5, 32'hDEAD, 0, 0, 0, "t5_unknown");
    @(negedge clk);
    check("t5_rd_err_unknown", {31'd0, rd_err}, 1);
    tick();
    r_beat(1, 32'hC0DE, 2, 0, 1, "t5_slverr");
    check("t5_rd_err_sticky", {31'd0, rd_err}, 1);
    $display("[TB] error handling done");

    // Reset mid-transaction
    arready = 0; i_req = 1; i_addr = 32'h80;
    @(negedge clk);
    check("t6_addr_ok", {31'd0, i_addr_ok}, 1);
    tick(); i_req = 0;
    @(negedge clk);
    check("t6_arvalid_pre", {31'd0, arvalid}, 1);
    tick(); rst = 1;
    tick(); rvalid = 1; rid = 0; rdata = 32'h55;
    @(negedge clk);
    check("t6_arvalid_rst", {31'd0, arvalid}, 0);
    check("t6_rready_rst", {31'd0, rready}, 0);
    check("t6_no_data_ok", {31'd0, i_data_ok}, 0);
    check("t6_rd_err_clr", {31'd0, rd_err}, 0);
    tick(); rst = 0; rvalid = 0;
    tick();
    arready = 1; i_req = 1; cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); if (i_addr_ok) cnt++; tick();
    end
    check("t6_count_cleared", cnt, 2);
    i_req = 0;
    r_beat(0, 32'hE0, 0, 1, 0, "t6_drain0");
    r_beat(0, 32'hE1, 0, 1, 0, "t6_drain1");
    $display("[TB] reset mid-transaction done");

    // Randomized phase
    defaults();
    rand_on = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (i_fire_n || $urandom % 4 == 0) begin
        i_req = $urandom % 2; i_addr = $urandom & 32'hFFFFFFFC;
      end
      if (d_fire_n || $urandom % 4 == 0) begin
        d_req = $urandom % 2; d_addr = d_set[$urandom % 4]; d_size = 2'($urandom % 3);
      end
      if ($urandom % 4 == 0) begin
        wr_pending = $urandom % 2; wr_addr = d_set[$urandom % 4];
      end
      slave_step();
    end
    tick();
    i_req = 0; d_req = 0; wr_pending = 0;
    for (int c = 0; c < 500 && (out_i + out_d + exp_ar.size()) != 0; c++) begin
      slave_step();
      tick();
    end
    check("rnd_drained", out_i + out_d + exp_ar.size(), 0);
    check("rnd_inst_grants_seen", {31'd0, n_gi > 0}, 1);
    check("rnd_data_grants_seen", {31'd0, n_gd > 0}, 1);
    check("rnd_no_rd_err", {31'd0, rd_err}, 0);
    rand_on = 0;
    $display("[TB] random phase: %0d inst, %0d data reads", n_gi, n_gd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
